// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// FSM state encodings plus the default datapath widths.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_signed(op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage connection to the multiply/divide unit: launch, operands,
// MTHI/MTLO writes, and the HI/LO/busy/divzero results.
interface muldiv_if;
  import muldiv_pkg::*;

  logic                     start;
  op_e                      op;
  logic [DEFAULT_WIDTH-1:0] srca;
  logic [DEFAULT_WIDTH-1:0] srcb;
  logic                     hi_we;
  logic                     lo_we;
  logic [DEFAULT_WIDTH-1:0] wd;
  logic                     busy;
  logic [DEFAULT_WIDTH-1:0] hi;
  logic [DEFAULT_WIDTH-1:0] lo;
  logic                     divzero;

  modport master (
    output start, op, srca, srcb, hi_we, lo_we, wd,
    input  busy, hi, lo, divzero
  );

  modport slave (
    input  start, op, srca, srcb, hi_we, lo_we, wd,
    output busy, hi, lo, divzero
  );

endinterface

// File: rtl/adder_32bit.sv
// 32-bit ripple-style adder with carry in/out; the shared add/subtract
// datapath of the multiply/divide iterations and sign fix-ups.
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One iteration per cycle for WIDTH cycles, then one sign fix-up cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_hi_q, neg_hi_d;
  logic               neg_lo_q, neg_lo_d;
  logic               dz_pend_q, dz_pend_d;
  logic               divzero_q, divzero_d;

  logic [WIDTH-1:0]   lo_a, lo_b, lo_sum;
  logic               lo_cin, lo_cout;
  logic [WIDTH-1:0]   hi_a, hi_b, hi_sum;
  logic               hi_cin, hi_cout;

  logic               sgn_op, div_op, sa, sb, b_zero, trial_ok;
  logic [WIDTH:0]     partial;

  assign sgn_op   = op_is_signed(bus.op);
  assign div_op   = op_is_div(bus.op);
  assign sa       = sgn_op & bus.srca[WIDTH-1];
  assign sb       = sgn_op & bus.srcb[WIDTH-1];
  assign b_zero   = div_op & (bus.srcb == '0);
  assign partial  = {acc_q, mplr_q[WIDTH-1]};
  assign trial_ok = partial[WIDTH] | hi_cout;

  adder_32bit u_adder_lo (.a(lo_a), .b(lo_b), .cin(lo_cin), .sum(lo_sum), .cout(lo_cout));
  adder_32bit u_adder_hi (.a(hi_a), .b(hi_b), .cin(hi_cin), .sum(hi_sum), .cout(hi_cout));

  // Low adder: |srca| at launch, low-word negate in FIX.
  always_comb begin
    lo_a   = ~bus.srca;
    lo_b   = '0;
    lo_cin = 1'b1;
    if (state_q == S_FIX) lo_a = ~mplr_q;
  end

  // High adder: |srcb| at launch, the iteration step in RUN, high-word negate
  // in FIX (chained off the low carry when negating a 64-bit product).
  always_comb begin
    hi_a   = ~bus.srcb;
    hi_b   = '0;
    hi_cin = 1'b1;
    case (state_q)
      S_RUN: begin
        if (is_div_q) begin
          hi_a = partial[WIDTH-1:0];
          hi_b = ~mcand_q;
        end else begin
          hi_a   = acc_q;
          hi_b   = mplr_q[0] ? mcand_q : '0;
          hi_cin = 1'b0;
        end
      end
      S_FIX: begin
        hi_a   = ~acc_q;
        hi_cin = is_div_q ? 1'b1 : lo_cout;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mplr_d    = mplr_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_hi_d  = neg_hi_q;
    neg_lo_d  = neg_lo_q;
    dz_pend_d = dz_pend_q;
    divzero_d = divzero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_RUN;
          cnt_d     = CNT_W'(WIDTH);
          is_div_d  = div_op;
          dz_pend_d = b_zero;
          divzero_d = 1'b0;
          acc_d     = '0;
          neg_lo_d  = (sa ^ sb) & ~b_zero;
          neg_hi_d  = div_op ? (sa & ~b_zero) : (sa ^ sb);
          // A zero divisor keeps the raw dividend so it lands unmodified in HI.
          if (div_op) begin
            mplr_d  = (sa & ~b_zero) ? lo_sum : bus.srca;
            mcand_d = sb ? hi_sum : bus.srcb;
          end else begin
            mplr_d  = sb ? hi_sum : bus.srcb;
            mcand_d = sa ? lo_sum : bus.srca;
          end
        end else begin
          if (bus.hi_we) hi_d = bus.wd;
          if (bus.lo_we) lo_d = bus.wd;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        if (is_div_q) begin
          acc_d  = trial_ok ? hi_sum : partial[WIDTH-1:0];
          mplr_d = {mplr_q[WIDTH-2:0], trial_ok};
        end else begin
          acc_d  = {hi_cout, hi_sum[WIDTH-1:1]};
          mplr_d = {hi_sum[0], mplr_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        state_d   = S_IDLE;
        hi_d      = neg_hi_q ? hi_sum : acc_q;
        lo_d      = neg_lo_q ? lo_sum : mplr_q;
        divzero_d = dz_pend_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mplr_q    <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      dz_pend_q <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mplr_q    <= mplr_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_hi_q  <= neg_hi_d;
      neg_lo_q  <= neg_lo_d;
      dz_pend_q <= dz_pend_d;
      divzero_q <= divzero_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.divzero = divzero_q;

endmodule
